// File: rtl/sort_pkg.sv
// Shared types and constants for the 16-input sorting network and its loader.
package sort_pkg;

    localparam int W = 32;
    localparam int N = 16;

    // Unwritten lanes hold the maximum unsigned value so they sort to the top.
    localparam logic [W-1:0] PAD = {W{1'b1}};

    typedef logic [W-1:0]   elem_t;
    typedef logic [W*N-1:0] batch_t;
    typedef logic [4:0]     cnt_t;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    function automatic cnt_t idx_to_count(input logic [3:0] idx);
        return {1'b0, idx} + 5'd1;
    endfunction

endpackage

// File: rtl/sort16_batch_loader.sv
// Packs a valid/ready stream of W-bit words into 16-lane PAD-filled batches
// presented as one wide word with an element count.
module sort16_batch_loader
    import sort_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   in_valid,
    output logic   in_ready,
    input  elem_t  in_data,
    input  logic   in_last,
    output logic   out_valid,
    input  logic   out_ready,
    output batch_t out_data,
    output cnt_t   out_count
);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_idx;
    logic [3:0] w_idx_nxt;
    cnt_t       r_count;
    cnt_t       w_count_nxt;
    elem_t      r_lane [N];

    logic       w_in_ready;
    logic       w_out_valid;
    logic       w_in_xfer;
    logic       w_out_hs;
    logic       w_clear;
    logic       w_wr_en;
    logic [3:0] w_wr_idx;

    // Handshake readiness derived from the current state.
    always_comb begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            FILL: begin
                w_in_ready  = ~rst;
                w_out_valid = 1'b0;
            end
            HOLD: begin
                w_in_ready  = ~rst & out_ready;
                w_out_valid = 1'b1;
            end
            default: begin
                w_in_ready  = 1'b0;
                w_out_valid = 1'b0;
            end
        endcase
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign w_in_xfer = in_valid & w_in_ready;
    assign w_out_hs  = w_out_valid & out_ready;

    // Next state, fill index, count and lane-write controls.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_count_nxt = r_count;
        w_clear     = 1'b0;
        w_wr_en     = 1'b0;
        w_wr_idx    = r_idx;
        case (r_state)
            FILL: begin
                if (w_in_xfer) begin
                    w_wr_en = 1'b1;
                    if ((r_idx == 4'd15) || in_last) begin
                        w_state_nxt = HOLD;
                        w_count_nxt = idx_to_count(r_idx);
                        w_idx_nxt   = 4'd0;
                    end else begin
                        w_idx_nxt = r_idx + 4'd1;
                    end
                end else begin
                    w_state_nxt = FILL;
                end
            end
            HOLD: begin
                if (w_out_hs) begin
                    // Release: lanes return to PAD; a word accepted now opens the next batch.
                    w_clear     = 1'b1;
                    w_state_nxt = FILL;
                    w_idx_nxt   = 4'd0;
                    w_wr_idx    = 4'd0;
                    if (w_in_xfer) begin
                        w_wr_en = 1'b1;
                        if (in_last) begin
                            w_state_nxt = HOLD;
                            w_count_nxt = 5'd1;
                        end else begin
                            w_idx_nxt = 4'd1;
                        end
                    end else begin
                        w_wr_en = 1'b0;
                    end
                end else begin
                    w_state_nxt = HOLD;
                end
            end
            default: begin
                w_state_nxt = FILL;
                w_idx_nxt   = 4'd0;
            end
        endcase
    end

    // State, fill index and element count registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= FILL;
            r_idx   <= 4'd0;
            r_count <= 5'd0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_count <= w_count_nxt;
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_lane
        localparam logic [3:0] K = 4'(k);
        elem_t w_lane_nxt;

        // Lane update: a write wins over the release clear so lane 0 can take a word on release.
        always_comb begin
            w_lane_nxt = r_lane[k];
            if (w_wr_en && (w_wr_idx == K)) begin
                w_lane_nxt = in_data;
            end else if (w_clear) begin
                w_lane_nxt = PAD;
            end else begin
                w_lane_nxt = r_lane[k];
            end
        end

        // Lane storage register.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_lane[k] <= PAD;
            end else begin
                r_lane[k] <= w_lane_nxt;
            end
        end

        assign out_data[k*W +: W] = r_lane[k];
    end

    assign out_count = r_count;

endmodule
